spike_mac_scan_ctrl: RTL and testbench
======================================

SPIKE_MAC_SCAN_CTRL -- requirements
Module: spike_mac_scan_ctrl

Interface
REQ-001 The block SHALL take parameter INPUT_VEC_LEN, default 8, the number of spike inputs (matrix rows).
REQ-002 The block SHALL take parameter OUTPUT_VEC_LEN, default 8, the number of MAC outputs (matrix columns).
REQ-003 The block SHALL take parameter WIDTH, default 8, the weight word width in bits.
REQ-004 The block SHALL take parameter SC_MAC_OUT_WIDTH, default 128, the readback chain length in bits.
REQ-005 The block SHALL take parameter COMPUTE_CYCLES, default 4, the number of functional-mode cycles per run.
REQ-006 The block SHALL have port CLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, a run request.
REQ-009 The block SHALL have port spike_vec, input, INPUT_VEC_LEN bits, captured on an accepted start.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, WIDTH), forming the weight word stream.
REQ-012 The block SHALL have ports scanIn (output, 1), SC_EN (output, 1) and scanOut (input, 1), connecting to the spike MAC scan chain.
REQ-013 The block SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, SC_MAC_OUT_WIDTH), forming the result handshake.

Function
REQ-014 Derived constants SHALL be NW = INPUT_VEC_LEN*OUTPUT_VEC_LEN and L = INPUT_VEC_LEN + NW*WIDTH; L = 520 at the defaults.
REQ-015 The states SHALL be IDLE, LOAD, SHIFT, MARK, COMPUTE, READ and DONE.
REQ-016 In IDLE, start=1 SHALL capture spike_vec and move the state to LOAD on the next cycle; start SHALL be ignored in every other state.
REQ-017 In LOAD, w_ready SHALL be 1, each cycle with w_valid&w_ready SHALL store w_data as word k (k = 0..NW-1, arrival order = row-major, i*OUTPUT_VEC_LEN+j), and the cycle accepting word NW-1 SHALL move the state to SHIFT.
REQ-018 w_ready SHALL be 0 outside LOAD, and w_valid gaps in LOAD SHALL only stall loading.
REQ-019 SHIFT SHALL last exactly L cycles with SC_EN=1 and SHALL drive scanIn with spike bits 0..INPUT_VEC_LEN-1, then words 0..NW-1, each word LSB first, one bit per cycle.
REQ-020 MARK SHALL last 1 cycle with SC_EN=1 and scanIn=1.
REQ-021 COMPUTE SHALL last COMPUTE_CYCLES cycles with SC_EN=0 and scanIn=0.
REQ-022 READ SHALL last SC_MAC_OUT_WIDTH cycles with SC_EN=1 and scanIn=0, and res_data bit n SHALL equal scanOut sampled at the rising edge ending READ cycle n.
REQ-023 In DONE, res_valid SHALL be 1 with res_data stable, and res_valid&res_ready SHALL move the state to IDLE next cycle.
REQ-024 SC_EN SHALL be 0 in IDLE, LOAD and DONE, with no stall cycles inside SHIFT, MARK or READ.
REQ-025 Latency from the cycle after the last accepted word to res_valid SHALL be L+1+COMPUTE_CYCLES+SC_MAC_OUT_WIDTH cycles.
REQ-026 All counters SHALL be sized by $clog2 of their terminal count, and none SHALL wrap.

Reset
REQ-027 RESET=1 SHALL, at the next edge, force IDLE, busy=0, SC_EN=0, scanIn=0, w_ready=0, res_valid=0, res_data=0 and all counters to 0, from any state.
REQ-028 A reset mid-run SHALL discard loaded words, and a later run SHALL require a full reload.

Configuration
REQ-029 With macro SPIKE_MAC_READBACK_EN defined, the READ state and res_data capture SHALL exist as in REQ-022.
REQ-030 Without SPIKE_MAC_READBACK_EN, COMPUTE SHALL go directly to DONE, res_data SHALL be constant 0, and scanOut SHALL be unused.

Verification
REQ-031 Defaults, spike_vec=8'h80, word k={i[3:0],j[3:0]} streamed back-to-back: scanIn SHALL read 0,0,0,0,0,0,0,1 in the first 8 SHIFT cycles, then word 0x01 bits LSB first in cycles 16..23, and SC_EN SHALL stay 1 for 521 consecutive cycles ending with scanIn=1.
REQ-032 Same run, w_valid deasserted for 5 cycles after word 10: the SHIFT/MARK scanIn sequence SHALL be bit-identical to REQ-031.
REQ-033 start pulsed during SHIFT with a different spike_vec: it SHALL be ignored, with no effect on scanIn or state.
REQ-034 RESET asserted at SHIFT cycle 100: SC_EN=0 and busy=0 SHALL hold on the next cycle, and a full new run SHALL then complete correctly.
REQ-035 Readback enabled, scanOut driven with the pattern 128'hA5 repeated: res_data SHALL equal that pattern exactly 653 cycles after the last word is accepted.
REQ-036 res_ready held 0 for 20 cycles in DONE: res_valid and res_data SHALL hold, and IDLE SHALL follow one cycle after res_ready=1.

Source files
------------

// File: rtl/spike_mac_scan_ctrl.sv
// Loads spikes and weights, shifts them into the spike-MAC scan chain, runs it, then hands back the result.
// Optional readback of the MAC result chain is enabled by defining SPIKE_MAC_READBACK_EN.
module spike_mac_scan_ctrl #(
    parameter int unsigned INPUT_VEC_LEN    = 8,
    parameter int unsigned OUTPUT_VEC_LEN   = 8,
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned SC_MAC_OUT_WIDTH = 128,
    parameter int unsigned COMPUTE_CYCLES   = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        start,
    input  logic [INPUT_VEC_LEN-1:0]    spike_vec,
    output logic                        busy,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [WIDTH-1:0]            w_data,
    output logic                        scanIn,
    output logic                        SC_EN,
    input  logic                        scanOut,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [SC_MAC_OUT_WIDTH-1:0] res_data
);
    localparam int unsigned NW = INPUT_VEC_LEN * OUTPUT_VEC_LEN;
    localparam int unsigned L  = INPUT_VEC_LEN + NW * WIDTH;
    localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned BW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, MARK, COMPUTE, READ, DONE} state_t;

    state_t                   state, state_n;
    logic [KW-1:0]            kcnt;
    logic [BW-1:0]            bcnt;
    logic [CW-1:0]            ccnt;
    logic [INPUT_VEC_LEN-1:0] spike_q;
    logic [NW*WIDTH-1:0]      weights_q;
    logic [L-1:0]             chain;
    logic                     k_last, b_last, c_last;

`ifdef SPIKE_MAC_READBACK_EN
    localparam int unsigned RW = (SC_MAC_OUT_WIDTH > 1) ? $clog2(SC_MAC_OUT_WIDTH) : 1;
    logic [RW-1:0]               rcnt;
    logic                        r_last;
    logic [SC_MAC_OUT_WIDTH-1:0] res_q;

    assign r_last   = (rcnt == RW'(SC_MAC_OUT_WIDTH - 1));
    assign res_data = res_q;
`else
    logic unused_scan_out;

    assign unused_scan_out = scanOut;
    assign res_data        = '0;
`endif

    // Word k sits at bits [k*WIDTH +: WIDTH], so the chain bit index equals the SHIFT cycle index.
    assign chain  = {weights_q, spike_q};
    assign k_last = (kcnt == KW'(NW - 1));
    assign b_last = (bcnt == BW'(L - 1));
    assign c_last = (ccnt == CW'(COMPUTE_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            kcnt      <= '0;
            bcnt      <= '0;
            ccnt      <= '0;
            spike_q   <= '0;
            weights_q <= '0;
`ifdef SPIKE_MAC_READBACK_EN
            rcnt      <= '0;
            res_q     <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) spike_q <= spike_vec;
                end
                LOAD: begin
                    if (w_valid) begin
                        weights_q[int'(kcnt)*WIDTH +: WIDTH] <= w_data;
                        kcnt <= k_last ? '0 : kcnt + 1'b1;
                    end
                end
                SHIFT:   bcnt <= b_last ? '0 : bcnt + 1'b1;
                COMPUTE: ccnt <= c_last ? '0 : ccnt + 1'b1;
`ifdef SPIKE_MAC_READBACK_EN
                READ: begin
                    res_q[rcnt] <= scanOut;
                    rcnt        <= r_last ? '0 : rcnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        busy      = (state != IDLE);
        w_ready   = 1'b0;
        SC_EN     = 1'b0;
        scanIn    = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && k_last) state_n = SHIFT;
            end
            SHIFT: begin
                SC_EN  = 1'b1;
                scanIn = chain[bcnt];
                if (b_last) state_n = MARK;
            end
            MARK: begin
                SC_EN   = 1'b1;
                scanIn  = 1'b1;
                state_n = COMPUTE;
            end
            COMPUTE: begin
`ifdef SPIKE_MAC_READBACK_EN
                if (c_last) state_n = READ;
`else
                if (c_last) state_n = DONE;
`endif
            end
            READ: begin
`ifdef SPIKE_MAC_READBACK_EN
                SC_EN = 1'b1;
                if (r_last) state_n = DONE;
`else
                state_n = IDLE;
`endif
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spike_mac_scan_ctrl.sv
// Scoreboard bench for spike_mac_scan_ctrl; expected scan bits and results are queued as stimulus is driven.
// Works with or without SPIKE_MAC_READBACK_EN defined.
module tb_spike_mac_scan_ctrl;
    localparam int IVL = 8, OVL = 8, W = 8, SCW = 128, CC = 4;
    localparam int NW  = IVL * OVL;
    localparam int L   = IVL + NW * W;
`ifdef SPIKE_MAC_READBACK_EN
    localparam int RD = SCW;
    localparam bit RB = 1'b1;
`else
    localparam int RD = 0;
    localparam bit RB = 1'b0;
`endif
    localparam int EXP_LAT = L + 1 + CC + RD;

    logic           clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [IVL-1:0] spike_vec = '0;
    logic           busy, w_valid = 1'b0, w_ready;
    logic [W-1:0]   w_data = '0;
    logic           scanIn, SC_EN, scanOut = 1'b0;
    logic           res_valid, res_ready = 1'b0;
    logic [SCW-1:0] res_data;

    spike_mac_scan_ctrl #(
        .INPUT_VEC_LEN(IVL), .OUTPUT_VEC_LEN(OVL), .WIDTH(W),
        .SC_MAC_OUT_WIDTH(SCW), .COMPUTE_CYCLES(CC)
    ) dut (
        .CLK(clk), .RESET(rst), .start(start), .spike_vec(spike_vec), .busy(busy),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .scanIn(scanIn), .SC_EN(SC_EN), .scanOut(scanOut),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    int             passed = 0, total = 0;
    bit             exp_q[$], obs_q[$], ref_bits[$];
    logic [SCW-1:0] exp_res_q[$];
    logic [SCW-1:0] pat;
    int             lat, sc_run;

    // Drives one run and records the first SC_EN burst; rst_at >= 0 asserts RESET in that SHIFT cycle.
    task automatic drive_run(input logic [IVL-1:0] sp, input int gap_after, input bit pulse,
                             input int rst_at, output int status);
        int k, gap, cyc, n, rn;
        bit acc, burst_done, seen;
        status = 0; lat = -1; sc_run = 0;
        obs_q.delete(); exp_q.delete();
        @(negedge clk); start = 1'b1; spike_vec = sp;
        for (int b = 0; b < IVL; b++) exp_q.push_back(sp[b]);
        @(negedge clk); start = 1'b0; spike_vec = ~sp;
        k = 0; gap = 0; cyc = 0;
        while (k < NW && cyc < 1000) begin
            if (gap > 0) begin w_valid = 1'b0; gap--; end
            else begin w_valid = 1'b1; w_data = {4'(k / OVL), 4'(k % OVL)}; end
            acc = w_valid && w_ready;
            @(negedge clk); cyc++;
            if (acc) begin
                for (int b = 0; b < W; b++) exp_q.push_back(w_data[b]);
                k++;
                if (k == gap_after + 1) gap = 5;
            end
        end
        w_valid = 1'b0;
        if (k < NW) begin status = 1; return; end
        exp_q.push_back(1'b1);
        exp_res_q.push_back(RB ? pat : '0);
        n = 0; rn = 0; burst_done = 0; seen = 0;
        while (n < EXP_LAT + 200) begin
            if (res_valid) begin lat = n; break; end
            if (SC_EN && !burst_done) begin obs_q.push_back(scanIn); sc_run++; seen = 1; end
            else if (!SC_EN && seen) burst_done = 1;
            if (SC_EN && burst_done && rn < SCW) begin scanOut = pat[rn]; rn++; end
            else scanOut = 1'b1;
            if (pulse && sc_run == 50 && !burst_done) begin start = 1'b1; spike_vec = 8'h3C; end
            else start = 1'b0;
            if (rst_at >= 0 && sc_run == rst_at + 1) begin rst = 1'b1; status = 2; return; end
            @(negedge clk); n++;
        end
        start = 1'b0;
        if (lat < 0) status = 1;
    endtask

    function automatic int sb_mismatches();
        int m = 0;
        bit e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
            if (o != e) m++;
        end
        return m + obs_q.size();
    endfunction

    function automatic int ref_mismatches();
        int m = 0;
        for (int i = 0; i < obs_q.size(); i++) if (i >= ref_bits.size() || obs_q[i] != ref_bits[i]) m++;
        if (obs_q.size() != ref_bits.size()) m++;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (SC_EN !== 1'b0) $display("FAIL reset_sc_en got %b want 0", SC_EN); else passed++;
        total++; if (scanIn !== 1'b0) $display("FAIL reset_scanin got %b want 0", scanIn); else passed++;
        total++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready got %b want 0", w_ready); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else passed++;
        total++; if (res_data !== '0) $display("FAIL reset_res_data got %h want 0", res_data); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int st, m;
        logic [7:0] v0, v1;
        logic [SCW-1:0] er;
        drive_run(8'h80, -1, 1'b0, -1, st);
        total++; if (st !== 0) $display("FAIL b2b_status got %0d want 0", st); else passed++;
        for (int b = 0; b < 8; b++) begin v0[b] = obs_q[b]; v1[b] = obs_q[16 + b]; end
        total++; if (v0 !== 8'h80) $display("FAIL b2b_spike_bits got %h want 80", v0); else passed++;
        total++; if (v1 !== 8'h01) $display("FAIL b2b_word1_bits got %h want 01", v1); else passed++;
        total++; if (sc_run !== L + 1) $display("FAIL b2b_sc_en_run got %0d want %0d", sc_run, L + 1); else passed++;
        total++; if (obs_q[L] !== 1'b1) $display("FAIL b2b_mark got %b want 1", obs_q[L]); else passed++;
        total++; if (lat !== EXP_LAT) $display("FAIL b2b_latency got %0d want %0d", lat, EXP_LAT); else passed++;
        er = exp_res_q.pop_front();
        total++; if (res_data !== er) $display("FAIL b2b_res_data got %h want %h", res_data, er); else passed++;
        ref_bits = obs_q;
        m = sb_mismatches();
        total++; if (m !== 0) $display("FAIL b2b_stream got %0d bad bits want 0", m); else passed++;
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_gap();
        int st, m;
        logic [SCW-1:0] er;
        drive_run(8'h80, 10, 1'b0, -1, st);
        total++; if (st !== 0) $display("FAIL gap_status got %0d want 0", st); else passed++;
        m = ref_mismatches();
        total++; if (m !== 0) $display("FAIL gap_vs_b2b got %0d bad bits want 0", m); else passed++;
        m = sb_mismatches();
        total++; if (m !== 0) $display("FAIL gap_stream got %0d bad bits want 0", m); else passed++;
        er = exp_res_q.pop_front();
        total++; if (res_data !== er) $display("FAIL gap_res_data got %h want %h", res_data, er); else passed++;
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        int st, m;
        logic [SCW-1:0] er;
        drive_run(8'h80, -1, 1'b1, -1, st);
        total++; if (st !== 0) $display("FAIL ign_status got %0d want 0", st); else passed++;
        m = ref_mismatches();
        total++; if (m !== 0) $display("FAIL ign_vs_b2b got %0d bad bits want 0", m); else passed++;
        m = sb_mismatches();
        total++; if (m !== 0) $display("FAIL ign_stream got %0d bad bits want 0", m); else passed++;
        total++; if (lat !== EXP_LAT) $display("FAIL ign_latency got %0d want %0d", lat, EXP_LAT); else passed++;
        er = exp_res_q.pop_front();
        total++; if (res_data !== er) $display("FAIL ign_res_data got %h want %h", res_data, er); else passed++;
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int st, m;
        logic [SCW-1:0] er;
        drive_run(8'h80, -1, 1'b0, 100, st);
        exp_res_q.delete();
        total++; if (st !== 2) $display("FAIL mid_reached_shift got %0d want 2", st); else passed++;
        @(negedge clk);
        total++; if (SC_EN !== 1'b0) $display("FAIL mid_sc_en got %b want 0", SC_EN); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passed++;
        total++; if (res_data !== '0) $display("FAIL mid_res_data got %h want 0", res_data); else passed++;
        rst = 1'b0;
        drive_run(8'h5A, 20, 1'b0, -1, st);
        total++; if (st !== 0) $display("FAIL mid_rerun_status got %0d want 0", st); else passed++;
        m = sb_mismatches();
        total++; if (m !== 0) $display("FAIL mid_rerun_stream got %0d bad bits want 0", m); else passed++;
        total++; if (lat !== EXP_LAT) $display("FAIL mid_rerun_latency got %0d want %0d", lat, EXP_LAT); else passed++;
        er = exp_res_q.pop_front();
        total++; if (res_data !== er) $display("FAIL mid_rerun_res_data got %h want %h", res_data, er); else passed++;
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_hold();
        int st, bad;
        logic [SCW-1:0] er;
        drive_run(8'hC3, -1, 1'b0, -1, st);
        total++; if (st !== 0) $display("FAIL hold_status got %0d want 0", st); else passed++;
        er = exp_res_q.pop_front();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (res_valid !== 1'b1 || res_data !== er) bad++;
            @(negedge clk);
        end
        total++; if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else passed++;
        total++; if (res_data !== er) $display("FAIL hold_res_data got %h want %h", res_data, er); else passed++;
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        total++; if (busy !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL hold_idle got busy=%b res_valid=%b want 0 0", busy, res_valid); else passed++;
    endtask

    initial begin
        pat = {16{8'hA5}};
        test_reset();
        test_back_to_back();
        test_gap();
        test_start_ignored();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
